// File: rtl/vend_pkg.sv
// Shared encodings and widths for the vending controller and its stock bank.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        RETURN = 2'd3
    } state_t;

    localparam int CREDIT_W  = 4;
    localparam int STOCK_W   = 3;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    localparam logic [CREDIT_W-1:0] FIFTY_VAL  = 4'd1;
    localparam logic [CREDIT_W-1:0] DOLLAR_VAL = 4'd2;

endpackage

// File: rtl/vend_stock_bank.sv
// Four per-slot stock counters: reload, guarded decrement, empty flag for the selected slot.
// Updates land on the next edge; the empty flag is combinational from the counters.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int STOCK_INIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic              dec,
    input  logic [SLOT_W-1:0] dec_slot,
    input  logic [SLOT_W-1:0] sel,
    output logic              empty
);

    logic [STOCK_W-1:0] stock [NUM_SLOTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (reload) begin
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec && stock[dec_slot] != '0) begin
            stock[dec_slot] <= stock[dec_slot] - STOCK_W'(1);
        end
    end

    assign empty = (stock[sel] == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin credit, slot arbitration, motor handshake with watchdog, change pulser.
// All outputs registered, one cycle after the sampled input; no backpressure, pulses are fire-and-forget.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 6,
    parameter int STOCK_INIT = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifty,
    input  logic                dollar,
    input  logic                cancel,
    input  logic                sel_valid,
    input  logic [SLOT_W-1:0]   sel,
    input  logic                restock,
    input  logic                motor_done,
    output logic                insert_coin,
    output logic                coin_reject,
    output logic                dispense_req,
    output logic [SLOT_W-1:0]   dispense_slot,
    output logic                change_pulse,
    output logic                sold_out,
    output logic                fault,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          sst
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
    localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [WD_W-1:0]     wdog, wdog_nxt;
    logic [SLOT_W-1:0]   slot_nxt;
    logic                fault_nxt, reject_nxt, req_nxt, change_nxt, sold_nxt;
    logic                stock_dec, stock_reload, slot_empty;

    logic                coin_any, coin_fits;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;

    assign coin_any  = fifty | dollar;
    assign coin_val  = dollar ? DOLLAR_VAL : FIFTY_VAL;
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    // Two coins in one cycle are both bounced with a single reject pulse.
    assign coin_fits = !(fifty && dollar) && (coin_sum <= {1'b0, MAX_C});

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        wdog_nxt     = '0;
        slot_nxt     = dispense_slot;
        fault_nxt    = fault;
        reject_nxt   = 1'b0;
        req_nxt      = 1'b0;
        change_nxt   = 1'b0;
        sold_nxt     = 1'b0;
        stock_dec    = 1'b0;
        stock_reload = 1'b0;

        case (state)
            IDLE: begin
                if (restock) begin
                    stock_reload = 1'b1;
                    fault_nxt    = 1'b0;
                end
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        state_nxt  = CREDIT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            CREDIT: begin
                if (cancel) begin
                    state_nxt  = RETURN;
                    reject_nxt = coin_any;
                end else if (sel_valid && credit >= PRICE_C && !slot_empty) begin
                    state_nxt  = VEND;
                    credit_nxt = credit - PRICE_C;
                    slot_nxt   = sel;
                    req_nxt    = 1'b1;
                    reject_nxt = coin_any;
                end else begin
                    sold_nxt = sel_valid && credit >= PRICE_C;
                    if (coin_any) begin
                        if (coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
                        else           reject_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                reject_nxt = coin_any;
                if (motor_done) begin
                    stock_dec = 1'b1;
                    state_nxt = (credit != '0) ? RETURN : IDLE;
                end else if (wdog == WD_LAST) begin
                    // Motor never answered: give the price back and flag it.
                    credit_nxt = credit + PRICE_C;
                    fault_nxt  = 1'b1;
                    state_nxt  = RETURN;
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                    req_nxt  = 1'b1;
                end
            end
            RETURN: begin
                reject_nxt = coin_any;
                if (credit == '0) begin
                    state_nxt = IDLE;
                end else if (!change_pulse) begin
                    change_nxt = 1'b1;
                    credit_nxt = credit - CREDIT_W'(1);
                    if (credit == CREDIT_W'(1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            credit        <= '0;
            wdog          <= '0;
            dispense_slot <= '0;
            fault         <= 1'b0;
            insert_coin   <= 1'b1;
            coin_reject   <= 1'b0;
            dispense_req  <= 1'b0;
            change_pulse  <= 1'b0;
            sold_out      <= 1'b0;
        end else begin
            state         <= state_nxt;
            credit        <= credit_nxt;
            wdog          <= wdog_nxt;
            dispense_slot <= slot_nxt;
            fault         <= fault_nxt;
            insert_coin   <= (state_nxt == IDLE);
            coin_reject   <= reject_nxt;
            dispense_req  <= req_nxt;
            change_pulse  <= change_nxt;
            sold_out      <= sold_nxt;
        end
    end

    assign sst = state;

    vend_stock_bank #(
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .reload   (stock_reload),
        .dec      (stock_dec),
        .dec_slot (dispense_slot),
        .sel      (sel),
        .empty    (slot_empty)
    );

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: vector table plus hand-written multi-cycle sequences.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifty = 1'b0, dollar = 1'b0, cancel = 1'b0, sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       restock = 1'b0, motor_done = 1'b0;
    logic       insert_coin, coin_reject, dispense_req, change_pulse, sold_out, fault;
    logic [1:0] dispense_slot, sst;
    logic [3:0] credit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vend_controller #(
        .PRICE(3), .MAX_CREDIT(6), .STOCK_INIT(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .fifty(fifty), .dollar(dollar), .cancel(cancel),
        .sel_valid(sel_valid), .sel(sel), .restock(restock), .motor_done(motor_done),
        .insert_coin(insert_coin), .coin_reject(coin_reject), .dispense_req(dispense_req),
        .dispense_slot(dispense_slot), .change_pulse(change_pulse), .sold_out(sold_out),
        .fault(fault), .credit(credit), .sst(sst)
    );

    // in  = {fifty, dollar, cancel, sel_valid, sel[1:0], restock, motor_done}
    // exp = {sst[1:0], credit[3:0], insert_coin, coin_reject, dispense_req,
    //        dispense_slot[1:0], change_pulse, sold_out, fault}
    typedef struct {
        logic [7:0]  in;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int f, d, c, sv, sl, rs, md,
                                input int st, cr, ic, rej, req, slot, chg, so, flt);
        vec_t v;
        v.in  = {1'(f), 1'(d), 1'(c), 1'(sv), 2'(sl), 1'(rs), 1'(md)};
        v.exp = {2'(st), 4'(cr), 1'(ic), 1'(rej), 1'(req), 2'(slot), 1'(chg), 1'(so), 1'(flt)};
        return v;
    endfunction

    function automatic logic [13:0] out_now();
        return {sst, credit, insert_coin, coin_reject, dispense_req,
                dispense_slot, change_pulse, sold_out, fault};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] in);
        {fifty, dollar, cancel, sel_valid, sel, restock, motor_done} = in;
        tick();
        {fifty, dollar, cancel, sel_valid, sel, restock, motor_done} = '0;
    endtask

    // Shorthand single-input pulses
    task automatic p_fifty();      apply(8'b1000_0000); endtask
    task automatic p_dollar();     apply(8'b0100_0000); endtask
    task automatic p_cancel();     apply(8'b0010_0000); endtask
    task automatic p_done();       apply(8'b0000_0001); endtask
    task automatic p_restock();    apply(8'b0000_0010); endtask
    task automatic p_sel(input logic [1:0] s); apply({4'b0001, s, 2'b00}); endtask

    int n, np, k;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(out_now()), int'({2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Vend exact price at slot 2, motor answers after 4 VEND cycles
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,2,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,3,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,2,0,0, 2,0,0,0,1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 2,0,0,0,1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 2,0,0,0,1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 2,0,0,0,1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,1,0,0,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,2,0,0,0));
        // Overpay by 50c at slot 0: one change pulse
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,2,0,0,0,2,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,4,0,0,0,2,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 2,1,0,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 3,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0,0));
        // Credit ceiling reject, then cancel refunds 5 units over 9 RETURN cycles
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,3,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,5,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,5,0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 3,5,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,4,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,4,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,3,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,3,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,2,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,2,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,1,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0,0));
        // Coin + cancel together: coin bounced, only prior credit refunded
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,2,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,0,0, 3,2,0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,1,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 3,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0,1,0,0));
        // Both coins at once in IDLE, then ignored selection and stray motor_done
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,0,1,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,0, 0,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0));
        // Selection below price is ignored
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,3,0,0, 1,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 3,1,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,1,0,0,0,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].in);
            check($sformatf("vec%0d", i), int'(out_now()), int'(vecs[i].exp));
        end

        // Drain slot 1 (4 units), then selecting it reports sold out
        for (int v = 0; v < 4; v++) begin
            p_dollar(); p_fifty(); p_sel(2'd1);
            check($sformatf("drain%0d_vend", v), int'(sst), 2);
            p_done();
            check($sformatf("drain%0d_idle", v), int'({sst, credit}), int'({2'd0, 4'd0}));
        end
        p_dollar(); p_fifty(); p_sel(2'd1);
        check("sold_out_pulse", int'({sold_out, sst, credit}), int'({1'b1, 2'd1, 4'd3}));
        tick();
        check("sold_out_clears", int'({sold_out, sst, credit}), int'({1'b0, 2'd1, 4'd3}));
        p_sel(2'd2);
        check("slot2_still_stocked", int'({sst, dispense_req, dispense_slot}), int'({2'd2, 1'b1, 2'd2}));
        p_done();
        check("slot2_done", int'(sst), 0);

        // Motor timeout: 15 cycles of dispense_req, fault, 3 unit refund
        p_dollar(); p_fifty(); p_sel(2'd3);
        check("to_req_rise", int'({dispense_req, dispense_slot}), int'({1'b1, 2'd3}));
        n = 1;
        p_fifty();
        check("vend_coin_reject", int'({coin_reject, credit}), int'({1'b1, 4'd0}));
        if (dispense_req) n++;
        while (dispense_req && n < 40) begin
            tick();
            if (dispense_req) n++;
        end
        check("to_req_cycles", n, 15);
        check("to_fault_refund", int'({fault, sst, credit}), int'({1'b1, 2'd3, 4'd3}));
        np = 0;
        k  = 0;
        while (sst != 2'd0 && k < 20) begin
            tick();
            k++;
            if (change_pulse) np++;
        end
        check("to_refund_pulses", np, 3);
        check("to_idle_fault_sticky", int'({sst, credit, fault}), int'({2'd0, 4'd0, 1'b1}));
        p_restock();
        check("restock_clears_fault", int'(fault), 0);
        p_dollar(); p_fifty(); p_sel(2'd1);
        check("restock_reloads_slot1", int'({sst, dispense_slot, sold_out}), int'({2'd2, 2'd1, 1'b0}));
        p_done();

        // Asynchronous reset in the middle of a refund
        p_dollar(); p_dollar(); p_cancel();
        tick();
        check("pre_reset_return", int'({sst, credit, change_pulse}), int'({2'd3, 4'd3, 1'b1}));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", int'(out_now()), int'({2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_reset_idle", int'({sst, credit, insert_coin}), int'({2'd0, 4'd0, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Multi-slot vending controller that sequences the coin/dispense datapath of the lab vending system. It accumulates credit from 50c and $1 coin pulses, arbitrates a product selection against price and per-slot stock, and drives a dispense-motor handshake with a watchdog. It then returns change one 50c pulse at a time. It sits between the coin/button front end and the dispense motor driver, replacing the single-product FSM as the top-level controller.

## Interface
- PRICE, 3, product price in 50c units (3 = $1.50); must be 1..MAX_CREDIT
- MAX_CREDIT, 6, credit ceiling in 50c units; 4-bit credit register
- STOCK_INIT, 4, per-slot stock loaded on reset/restock; 3-bit counters
- TIMEOUT, 15, cycles allowed for motor_done after dispense_req rises
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fifty  in  1  one-cycle pulse: 50c coin inserted
- dollar  in  1  one-cycle pulse: $1 coin inserted
- cancel  in  1  one-cycle pulse: abort and refund
- sel_valid  in  1  one-cycle pulse: selection made
- sel  in  2  selected slot 0..3, valid with sel_valid
- restock  in  1  one-cycle pulse: reload all slots to STOCK_INIT
- motor_done  in  1  motor driver completion pulse
- insert_coin  out  1  high in IDLE (prompt)
- coin_reject  out  1  one-cycle pulse: coin not accepted, return physically
- dispense_req  out  2→1  held high in VEND until motor_done or timeout
- dispense_slot  out  2  slot being vended, stable while dispense_req high
- change_pulse  out  1  one-cycle pulse per 50c returned
- sold_out  out  1  one-cycle pulse: selected slot empty
- fault  out  1  sticky; set on motor timeout, cleared by reset or restock
- credit  out  4  current credit in 50c units
- sst  out  2  state: IDLE=0, CREDIT=1, VEND=2, RETURN=3

## Operation
- Reset: sst=IDLE, credit=0, stock[0..3]=STOCK_INIT, insert_coin=1, all pulses/dispense_req/fault=0, dispense_slot=0, watchdog=0.
- Coin value: fifty=1, dollar=2. Accepted only in IDLE/CREDIT and only if credit+value ≤ MAX_CREDIT; otherwise coin_reject. fifty and dollar in the same cycle: both rejected, one coin_reject pulse.
- IDLE: accepted coin → CREDIT. sel_valid and cancel ignored. restock honoured only here.
- CREDIT: coins accumulate. cancel → RETURN; cancel wins over a same-cycle coin (coin rejected) and over sel_valid. sel_valid with credit<PRICE is ignored. sel_valid with stock[sel]=0 raises sold_out and stays in CREDIT. sel_valid with credit≥PRICE and stock>0 → VEND, credit -= PRICE, dispense_slot=sel.
- VEND: dispense_req=1 and watchdog counts. On motor_done: stock[slot] -= 1, then RETURN if credit>0, else IDLE. If the watchdog reaches TIMEOUT without motor_done: credit += PRICE (refund), fault=1, stock unchanged, → RETURN. Coins are rejected here; cancel/sel ignored.
- RETURN: alternate change_pulse high/low each cycle and decrement credit on each pulse. On the cycle credit reaches 0 → IDLE. Coins are rejected here; other inputs ignored.
- A sel with an empty slot never decrements stock below 0. A motor_done outside VEND is ignored.

## Timing
- All outputs are registered. Inputs are sampled on the rising clk edge.
- Coin to credit update: 1 cycle. The coin_reject pulse appears in the same cycle credit would have updated.
- Accepted sel_valid: sst=VEND and dispense_req=1 on the next edge.
- motor_done: dispense_req drops on the next edge. The first change_pulse comes 1 cycle after entering RETURN.
- Refund of N units takes 2N−1 cycles of RETURN, then IDLE.
- Timeout: dispense_req drops at the edge where watchdog = TIMEOUT.
- Asserting rst mid-operation immediately forces reset values. Credit in flight is lost, by design; the operator refunds it manually.

## Structure
- The shared package vend_pkg holds state encodings (IDLE/CREDIT/VEND/RETURN), coin value constants, and the credit/stock widths.
- One sub-module, vend_stock_bank, holds the four 3-bit counters. It provides reload, decrement-by-slot and an empty flag for the selected slot.
- The FSM, credit register, watchdog and change pulser live in vend_controller.

## Test plan
- dollar, fifty (credit=3), sel_valid sel=2 → VEND; motor_done after 4 cycles → stock[2]=3, credit=0, IDLE, no change_pulse.
- dollar, dollar (credit=4), sel_valid sel=0, motor_done → exactly 1 change_pulse, credit=0, IDLE.
- fifty, dollar, dollar (credit=5), then another dollar → coin_reject pulse, credit stays 5; cancel → 5 change_pulses over 9 cycles, then IDLE.
- Drain slot 1 with 4 vends, then credit=3 and sel_valid sel=1 → sold_out pulse, still CREDIT, credit=3.
- Accepted vend with no motor_done → dispense_req drops after 15 cycles, fault=1, credit=3 refunded as 3 change_pulses; restock clears fault.
- In CREDIT, fifty+cancel in the same cycle → coin_reject, refund of the prior credit only. rst low during RETURN → sst=0, credit=0 asynchronously.
